// File: rtl/ht1632_frame_tx.sv
// HT1632 serial transmitter: sends three init commands after reset, then shifts out frames MSB first.
// Frame latency H*(2*FRAME_BITS+3) cycles; frame_ready only in IDLE, frame_valid elsewhere is ignored.
module ht1632_frame_tx #(
  parameter int         FRAME_BITS = 394,
  parameter int         CLK_DIV    = 50,
  parameter logic [7:0] COM_CMD    = 8'h24
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  cs,
  output logic                  write,
  output logic                  data
);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_CGAP = DW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    INIT, CMD_SETUP, CMD_SHIFT, CMD_GAP, IDLE, FR_SETUP, FR_SHIFT, FR_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic                  ph_q, ph_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            cmd_byte;
  logic                  hend;

  always_comb begin
    cmd_byte = COM_CMD;
    case (idx_q)
      2'd0:    cmd_byte = 8'h01;
      2'd1:    cmd_byte = 8'h03;
      default: cmd_byte = COM_CMD;
    endcase
  end

  assign hend = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q <= INIT;
      div_q   <= '0;
      ph_q    <= 1'b0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = hend ? '0 : div_q + DW'(1);
    ph_d        = ph_q;
    bcnt_d      = bcnt_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    cs          = 1'b1;
    write       = 1'b1;
    data        = 1'b0;
    frame_ready = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b1;
    case (state_q)
      // INIT is a cs-high cycle, so the command gap below is one cycle short of 2H.
      INIT: begin
        sh_d    = {3'b100, cmd_byte, 1'b0, {(FRAME_BITS-12){1'b0}}};
        bcnt_d  = BW'(12);
        div_d   = '0;
        ph_d    = 1'b0;
        state_d = CMD_SETUP;
      end
      CMD_SETUP, FR_SETUP: begin
        cs   = 1'b0;
        data = sh_q[FRAME_BITS-1];
        if (hend) begin
          ph_d    = 1'b0;
          state_d = (state_q == CMD_SETUP) ? CMD_SHIFT : FR_SHIFT;
        end
      end
      CMD_SHIFT, FR_SHIFT: begin
        cs    = 1'b0;
        write = ph_q;
        data  = sh_q[FRAME_BITS-1];
        if (hend) begin
          ph_d = ~ph_q;
          // Advance only after phase B so data changes with the falling WR edge.
          if (ph_q) begin
            sh_d   = sh_q << 1;
            bcnt_d = bcnt_q - BW'(1);
            if (bcnt_q == BW'(1)) begin
              state_d = (state_q == CMD_SHIFT) ? CMD_GAP : FR_GAP;
            end
          end
        end
      end
      CMD_GAP: begin
        if (ph_q && (div_q == DIV_CGAP)) begin
          div_d   = '0;
          ph_d    = 1'b0;
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd2) ? IDLE : INIT;
        end else if (hend) begin
          ph_d = 1'b1;
        end
      end
      IDLE: begin
        busy        = 1'b0;
        frame_ready = 1'b1;
        if (frame_valid) begin
          sh_d    = frame_data;
          bcnt_d  = BW'(FRAME_BITS);
          div_d   = '0;
          ph_d    = 1'b0;
          state_d = FR_SETUP;
        end
      end
      FR_GAP: begin
        if (hend) begin
          ph_d = 1'b1;
          if (ph_q) begin
            frame_done = 1'b1;
            ph_d       = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end
endmodule
